// File: rtl/riscv_dmem.sv
// riscv_dmem -- data-memory responder for the RISC-V core's load/store port.
//
// Accepts one request at a time, waits WAIT_CYCLES cycles, then answers with
// a one-cycle ready_o pulse. Writes are byte-lane masked and commit on the
// clock edge that ends the response cycle. Reads return the full word.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   BASE_ADDR    byte address of word 0 (aligned to DEPTH_WORDS*4)
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en_i        request valid
//   rw_i        1 = write, 0 = read
//   mem_addr_i  byte address
//   wdata_i     write data (core ddatout)
//   be_i        byte-lane strobes, be_i[i] covers bits [8i+7:8i]
//   rdata_o     read data (core ddatin)
//   ready_o     one-cycle response pulse
//   err_o       error flag, meaningful only while ready_o = 1
//
// Optional feature: define RISCV_DMEM_ALIGN_CHECK_EN to flag misaligned
// word / halfword accesses as errors. Without it, mem_addr_i[1:0] is ignored.

module riscv_dmem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_C = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            rw_q;
  logic            bad_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            ready_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  // Decode of the incoming request: offset, word index and error status.
  logic [31:0]     in_off;
  logic [AW-1:0]   in_idx;
  logic            in_bad;

  assign in_off = mem_addr_i - BASE_ADDR;
  assign in_idx = in_off[AW+1:2];

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    in_bad = (mem_addr_i < BASE_ADDR) ||
             ({32'd0, in_off} >= (64'(DEPTH_WORDS) << 2));
`ifdef RISCV_DMEM_ALIGN_CHECK_EN
    if ((be_i == 4'b1111) && (mem_addr_i[1:0] != 2'b00)) in_bad = 1'b1;
    if (((be_i == 4'b0011) || (be_i == 4'b1100)) && mem_addr_i[0]) in_bad = 1'b1;
`endif
  end

  // Request handshake and response selection.
  logic            accept;
  logic            go_resp;
  logic            resp_rw;
  logic            resp_bad;
  logic [AW-1:0]   resp_idx;
  logic            commit;
  logic [31:0]     rd_word;

  assign accept   = en_i && (state_q != S_WAIT);
  assign go_resp  = (accept && (WAIT_C == 4'd0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));
  // With zero wait, the response is built straight from the incoming request.
  assign resp_rw  = accept ? rw_i   : rw_q;
  assign resp_bad = accept ? in_bad : bad_q;
  assign resp_idx = accept ? in_idx : idx_q;
  // The latched write commits on the edge that ends its RESP cycle.
  assign commit   = (state_q == S_RESP) && rw_q && !bad_q;

  always_comb begin
    rd_word = mem_q[resp_idx];
    // A zero-wait read accepted in a write's RESP cycle must see the new data,
    // which only lands in the array on this same edge: forward it.
    if (commit && (idx_q == resp_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) rd_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept) begin
            rw_q    <= rw_i;
            bad_q   <= in_bad;
            idx_q   <= in_idx;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            cnt_q   <= WAIT_C;
            state_q <= (WAIT_C == 4'd0) ? S_RESP : S_WAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= resp_bad;
        // Writes leave rdata untouched; failed reads return zero.
        if (!resp_rw) rdata_q <= resp_bad ? 32'd0 : rd_word;
      end
    end
  end

  // NOTE: the storage array has no reset; only control state is cleared by rst_n.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_riscv_dmem.sv
// Directed testbench for riscv_dmem (DEPTH_WORDS=1024, BASE_ADDR=0,
// WAIT_CYCLES=1). Latency is counted in falling edges after the accepting
// rising edge: with one wait cycle, ready is first seen on the second one.

module tb_riscv_dmem;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rw;
  logic [31:0] mem_addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  riscv_dmem #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .WAIT_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .rw_i      (rw),
    .mem_addr_i(mem_addr),
    .wdata_i   (wdata),
    .be_i      (be),
    .rdata_o   (rdata),
    .ready_o   (ready),
    .err_o     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for its response.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output logic [31:0] rd,
                        output logic e);
    @(negedge clk);
    en = 1'b1; rw = w; mem_addr = a; wdata = d; be = b;
    @(posedge clk);
    #1 en = 1'b0;
    lat = -1; rd = 32'd0; e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n; rd = rdata; e = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; rw = 1'b0; mem_addr = 32'd0; wdata = 32'd0; be = 4'd0;
    #12;
    total_cnt++; if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else pass_cnt++;
    total_cnt++; if (rdata !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic e;
    do_req(1'b1, 32'h20, 32'h1234_5678, 4'hF, lat, rd, e);
    total_cnt++; if (lat !== 2) $display("FAIL word_wr_latency got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL word_wr_err got=%b exp=0", e); else pass_cnt++;
    total_cnt++; if (rd !== 32'd0) $display("FAIL word_wr_rdata_hold got=%h exp=0", rd); else pass_cnt++;
    do_req(1'b0, 32'h20, 32'd0, 4'hF, lat, rd, e);
    total_cnt++; if (lat !== 2) $display("FAIL word_rd_latency got=%0d exp=2", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'h1234_5678) $display("FAIL word_rd_data got=%h exp=12345678", rd); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL word_rd_err got=%b exp=0", e); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (ready !== 1'b0) $display("FAIL word_ready_pulse got=%b exp=0", ready); else pass_cnt++;
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic e;
    do_req(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0100, lat, rd, e);
    do_req(1'b0, 32'h20, 32'd0, 4'hF, lat, rd, e);
    total_cnt++; if (rd !== 32'h12FF_5678) $display("FAIL lane_merge got=%h exp=12ff5678", rd); else pass_cnt++;
    do_req(1'b1, 32'h20, 32'h0000_0000, 4'b0000, lat, rd, e);
    total_cnt++; if (e !== 1'b0 || lat !== 2) $display("FAIL be0_write got err=%b lat=%0d exp err=0 lat=2", e, lat); else pass_cnt++;
    do_req(1'b0, 32'h20, 32'd0, 4'hF, lat, rd, e);
    total_cnt++; if (rd !== 32'h12FF_5678) $display("FAIL be0_noop got=%h exp=12ff5678", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pattern;
    logic [31:0] rd;
    logic        e;
    pattern = 4'd0; rd = 32'd0; e = 1'b1;
    @(negedge clk);
    en = 1'b1; rw = 1'b1; mem_addr = 32'h40; wdata = 32'hA5A5_A5A5; be = 4'hF;
    @(posedge clk);
    #1 rw = 1'b0; wdata = 32'd0;   // en stays high: the read waits in line
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      pattern[n] = ready;
      if (n == 1) e = err;
      if (n == 3) begin rd = rdata; en = 1'b0; end
    end
    total_cnt++; if (pattern !== 4'b1010) $display("FAIL b2b_ready_pattern got=%b exp=1010", pattern); else pass_cnt++;
    total_cnt++; if (e !== 1'b0) $display("FAIL b2b_wr_err got=%b exp=0", e); else pass_cnt++;
    total_cnt++; if (rd !== 32'hA5A5_A5A5) $display("FAIL b2b_raw got=%h exp=a5a5a5a5", rd); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic e;
    do_req(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, lat, rd, e);
    do_req(1'b0, 32'h1000, 32'd0, 4'hF, lat, rd, e);
    total_cnt++; if (e !== 1'b1) $display("FAIL oor_rd_err got=%b exp=1", e); else pass_cnt++;
    total_cnt++; if (rd !== 32'd0) $display("FAIL oor_rd_data got=%h exp=0", rd); else pass_cnt++;
    do_req(1'b1, 32'h1000, 32'h1111_1111, 4'hF, lat, rd, e);
    total_cnt++; if (e !== 1'b1 || lat !== 2) $display("FAIL oor_wr got err=%b lat=%0d exp err=1 lat=2", e, lat); else pass_cnt++;
    do_req(1'b0, 32'h0, 32'd0, 4'hF, lat, rd, e);
    total_cnt++; if (rd !== 32'hCAFE_F00D) $display("FAIL oor_word0 got=%h exp=cafef00d", rd); else pass_cnt++;
    do_req(1'b1, 32'hFFC, 32'h0BAD_C0DE, 4'hF, lat, rd, e);
    do_req(1'b0, 32'hFFC, 32'd0, 4'hF, lat, rd, e);
    total_cnt++; if (rd !== 32'h0BAD_C0DE || e !== 1'b0) $display("FAIL last_word got=%h err=%b exp=0badc0de err=0", rd, e); else pass_cnt++;
  endtask

  task automatic test_align();
    int lat; logic [31:0] rd; logic e;
    do_req(1'b0, 32'h22, 32'd0, 4'hF, lat, rd, e);
`ifdef RISCV_DMEM_ALIGN_CHECK_EN
    total_cnt++; if (e !== 1'b1 || rd !== 32'd0) $display("FAIL align_rd got err=%b data=%h exp err=1 data=0", e, rd); else pass_cnt++;
`else
    total_cnt++; if (e !== 1'b0 || rd !== 32'h12FF_5678) $display("FAIL align_rd got err=%b data=%h exp err=0 data=12ff5678", e, rd); else pass_cnt++;
`endif
    total_cnt++; if (lat !== 2) $display("FAIL align_latency got=%0d exp=2", lat); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic e;
    // Reset during the RESP cycle of a read that returns non-zero data.
    @(negedge clk);
    en = 1'b1; rw = 1'b0; mem_addr = 32'h20; be = 4'hF;
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (ready !== 1'b1 || rdata !== 32'h12FF_5678) $display("FAIL rst_resp_pre got ready=%b data=%h exp ready=1 data=12ff5678", ready, rdata); else pass_cnt++;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) $display("FAIL rst_resp got ready=%b err=%b data=%h exp all 0", ready, err, rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    // Reset while a write sits in WAIT: the write must be discarded.
    do_req(1'b1, 32'h10, 32'h0000_1111, 4'hF, lat, rd, e);
    @(negedge clk);
    en = 1'b1; rw = 1'b1; mem_addr = 32'h10; wdata = 32'hDEAD_BEEF; be = 4'hF;
    @(posedge clk);
    #1 en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    total_cnt++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) $display("FAIL rst_wait got ready=%b err=%b data=%h exp all 0", ready, err, rdata); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 32'h10, 32'd0, 4'hF, lat, rd, e);
    total_cnt++; if (rd !== 32'h0000_1111 || lat !== 2) $display("FAIL rst_wr_discard got=%h lat=%0d exp=00001111 lat=2", rd, lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_align();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_dmem.md
# riscv_dmem

Data-memory responder for the RISC-V core's load/store port. It accepts one request at a time over the `en`/`rw`/`mem_addr` interface, waits a configurable number of cycles, then commits a byte-lane-masked write or returns a read word with a one-cycle `ready` pulse. It sits between the core's load/store unit and on-chip SRAM, and is the target that the core's load and store sequences talk to.

## Interface
- `DEPTH_WORDS`, 1024 — number of 32-bit words; power of two.
- `BASE_ADDR`, 32'h0000_0000 — byte address of word 0; aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, 1 — extra cycles between accept and response; 0–15.
- `clk` in 1 — rising-edge clock.
- `rst_n` in 1 — reset; asynchronous, active-low.
- `en` in 1 — request valid.
- `rw` in 1 — 1 = write, 0 = read.
- `mem_addr` in 32 — byte address.
- `wdata` in 32 — write data, driven by the core's `ddatout`.
- `be` in 4 — byte-lane strobes; `be[i]` covers bits `[8i+7:8i]`.
- `rdata` out 32 — read data, driven to the core's `ddatin`.
- `ready` out 1 — one-cycle response pulse.
- `err` out 1 — error flag, valid only while `ready`=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - On `en`=1: latch `rw`, `mem_addr`, `wdata` and `be`.
  - Go to WAIT and load the down-counter with `WAIT_CYCLES`; go straight to RESP if `WAIT_CYCLES`=0.
- **WAIT**
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - `en` is ignored here; the request is not queued.
- **RESP**
  - Assert `ready` for exactly this cycle.
  - Read: `rdata` = stored word; all 32 bits are returned regardless of `be`.
  - Write: update only lanes with `be[i]`=1 at the clock edge ending RESP. `rdata` holds its previous value.
  - If `en`=1 in RESP, accept the new request as IDLE does (back-to-back); otherwise return to IDLE.
- Word index = (`mem_addr` − `BASE_ADDR`) >> 2, using a 32-bit unsigned subtract.
- Out of range (`mem_addr` < `BASE_ADDR`, or index ≥ `DEPTH_WORDS`):
  - `err`=1 with `ready`.
  - Writes are suppressed; `rdata`=0.
- A write with `be`=4'b0000 is a legal no-op and completes normally with `err`=0.

## Timing
- Reset values: `ready`=0, `err`=0, `rdata`=0, FSM in IDLE, counter 0.
- Memory contents are not reset.
- Latency: `ready` rises `WAIT_CYCLES`+1 cycles after the accepting edge.
- Throughput: one request per `WAIT_CYCLES`+1 cycles when `en` is held high.
- Read-after-write: a read accepted in the RESP cycle of a write to the same word returns the new data.
- `rst_n` falling mid-operation:
  - Outputs clear immediately and the FSM returns to IDLE.
  - A write still in WAIT is discarded; a write whose RESP edge was already taken stays committed.
- `rst_n` release: the first request can be accepted on the first rising edge with `rst_n`=1.

## Configuration
- Macro: `RISCV_DMEM_ALIGN_CHECK_EN`.
- **Defined:** a request is misaligned when either:
  - `be`=4'b1111 and `mem_addr[1:0]`≠0; or
  - `be` ∈ {4'b0011, 4'b1100} and `mem_addr[0]`=1.
- A misaligned request completes with `err`=1, no write, and `rdata`=0, at normal latency.
- **Undefined:** `mem_addr[1:0]` is ignored; the word at index `mem_addr[31:2]` relative to `BASE_ADDR` is accessed. `err` reports range errors only.

## Test plan
- **Reset mid-access:** apply reset during WAIT of a write of 32'hDEAD_BEEF to 0x10 → `ready`/`err`/`rdata` = 0 immediately; a later read of 0x10 does not return 32'hDEAD_BEEF.
- **Word write/read:** with `WAIT_CYCLES`=1, write 32'h1234_5678 to 0x20 with `be`=4'hF, then read 0x20 → `ready` 2 cycles after each accept, `rdata`=32'h1234_5678, `err`=0.
- **Byte lanes:** write 32'hFFFF_FFFF to 0x20 with `be`=4'b0100 over 32'h1234_5678 → read returns 32'h12FF_5678.
- **Back-to-back:** hold `en` high for a write of 32'hA5A5_A5A5 to 0x40, then a read of 0x40 in its RESP cycle → read returns 32'hA5A5_A5A5; `ready` pulses every 2 cycles.
- **Out of range:** read at `BASE_ADDR`+`DEPTH_WORDS`*4 → `err`=1, `rdata`=0; a write there leaves word 0 unchanged.
- **Alignment check** (macro defined): word read at 0x22 → `err`=1. Macro undefined: the same read returns the word at 0x20 with `err`=0.
